// File: rtl/dmem_sram_responder.sv
// Word-addressed SRAM responder for the core data-memory port: byte-masked
// single-cycle writes, reads returned after RD_LAT cycles with ready/valid.
module dmem_sram_responder #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              OE_dm,
  input  logic [3:0]        WEB_dm,
  input  logic [31:0]       DI_dm,
  input  logic [ADDR_W-1:0] A_dm,
  output logic [31:0]       DO_dm,
  output logic              dm_ready,
  output logic              dm_valid
);

  // state | meaning
  // IDLE  | accepting requests; RD_LAT=1 reads also complete from here
  // BUSY  | multi-cycle read in flight, all request inputs ignored
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cnt;
  logic              wr_acc, rd_acc, done;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("dmem_sram_responder: RD_LAT must be within 1..4");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rd_acc && RD_LAT > 1) state_nxt = BUSY;
      BUSY: if (cnt == 2'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dm_ready = (state == IDLE);
    // A write mask wins over OE_dm, so a read needs every lane disabled.
    wr_acc   = dm_ready && (WEB_dm != 4'hF);
    rd_acc   = dm_ready && OE_dm && (WEB_dm == 4'hF);
    done     = (state == BUSY) && (cnt == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (!WEB_dm[i]) mem[A_dm][8*i +: 8] <= DI_dm[8*i +: 8];
      end
    end
  end

  // Storage cannot change while BUSY, so fetching at completion returns the
  // word as it stood on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      DO_dm    <= 32'h0;
      dm_valid <= 1'b0;
      cnt      <= 2'd0;
      addr_q   <= '0;
    end else begin
      dm_valid <= 1'b0;
      if (rd_acc) begin
        if (RD_LAT == 1) begin
          DO_dm    <= mem[A_dm];
          dm_valid <= 1'b1;
        end else begin
          addr_q <= A_dm;
          cnt    <= CNT_LOAD;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 2'd1;
        if (done) begin
          DO_dm    <= mem[addr_q];
          dm_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: three instances (RD_LAT 1, 3, 4) with a
// reference memory model and per-instance read-data scoreboards.
module tb_dmem_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  oe;
  logic [3:0]  web  [3];
  logic [31:0] di   [3];
  logic [13:0] a    [3];
  logic [31:0] dout [3];
  logic [2:0]  rdy, vld;

  logic [31:0] expq [3][$];
  logic [31:0] mdl [int];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_sram_responder #(.ADDR_W(14), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .OE_dm(oe[0]), .WEB_dm(web[0]), .DI_dm(di[0]),
    .A_dm(a[0]), .DO_dm(dout[0]), .dm_ready(rdy[0]), .dm_valid(vld[0]));
  dmem_sram_responder #(.ADDR_W(14), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .OE_dm(oe[1]), .WEB_dm(web[1]), .DI_dm(di[1]),
    .A_dm(a[1]), .DO_dm(dout[1]), .dm_ready(rdy[1]), .dm_valid(vld[1]));
  dmem_sram_responder #(.ADDR_W(14), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .OE_dm(oe[2]), .WEB_dm(web[2]), .DI_dm(di[2]),
    .A_dm(a[2]), .DO_dm(dout[2]), .dm_ready(rdy[2]), .dm_valid(vld[2]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int key(int k, logic [13:0] addr);
    return k * 65536 + int'(addr);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(int k, logic [13:0] addr, logic [3:0] we, logic [31:0] d);
    logic [31:0] w;
    a[k] = addr; web[k] = we; di[k] = d; oe[k] = 1'b0;
    step();
    web[k] = 4'hF;
    w = mdl.exists(key(k, addr)) ? mdl[key(k, addr)] : 32'h0;
    for (int i = 0; i < 4; i++) if (!we[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[key(k, addr)] = w;
  endtask

  task automatic rd(int k, logic [13:0] addr, int lat);
    a[k] = addr; web[k] = 4'hF; oe[k] = 1'b1;
    expq[k].push_back(mdl[key(k, addr)]);
    step();
    oe[k] = 1'b0;
    repeat (lat - 1) step();
  endtask

  task automatic mon(int k);
    logic [31:0] e;
    if (vld[k]) begin
      if (expq[k].size() == 0) begin
        check($sformatf("unexpected_valid_u%0d", k), {31'b0, vld[k]}, 32'h0);
      end else begin
        e = expq[k].pop_front();
        check($sformatf("rd_data_u%0d", k), dout[k], e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    oe  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      web[k] = 4'hF; di[k] = 32'h0; a[k] = 14'h0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_do_u%0d", k), dout[k], 32'h0);
      check($sformatf("rst_ready_u%0d", k), {31'b0, rdy[k]}, 32'h1);
      check($sformatf("rst_valid_u%0d", k), {31'b0, vld[k]}, 32'h0);
    end
    rst = 1'b0;
    step();

    // RD_LAT=1: full word, valid one cycle after the read edge
    wr(0, 14'h0010, 4'b0000, 32'hDEADBEEF);
    rd(0, 14'h0010, 1);
    check("lat1_valid", {31'b0, vld[0]}, 32'h1);
    check("lat1_ready", {31'b0, rdy[0]}, 32'h1);
    check("lat1_do", dout[0], 32'hDEADBEEF);
    step();
    check("lat1_valid_drop", {31'b0, vld[0]}, 32'h0);

    // byte-lane merges
    wr(0, 14'h0005, 4'b0000, 32'h11223344);
    wr(0, 14'h0005, 4'b1101, 32'h0000AB00);
    rd(0, 14'h0005, 1);
    check("merge1_do", dout[0], 32'h1122AB44);
    wr(0, 14'h0005, 4'b0011, 32'hCAFE0000);
    rd(0, 14'h0005, 1);
    check("merge2_do", dout[0], 32'hCAFEAB44);

    // OE with a write: write wins, no read
    a[0] = 14'h0007; oe[0] = 1'b1; web[0] = 4'b0000; di[0] = 32'h5A5A5A5A;
    step();
    oe[0] = 1'b0; web[0] = 4'hF;
    check("simul_no_valid", {31'b0, vld[0]}, 32'h0);
    check("simul_do_hold", dout[0], 32'hCAFEAB44);
    mdl[key(0, 14'h0007)] = 32'h5A5A5A5A;
    rd(0, 14'h0007, 1);
    check("simul_readback", dout[0], 32'h5A5A5A5A);

    // back-to-back reads
    for (int i = 0; i < 3; i++) wr(0, 14'(i), 4'b0000, 32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      a[0] = 14'(i); oe[0] = 1'b1; web[0] = 4'hF;
      expq[0].push_back(mdl[key(0, 14'(i))]);
      step();
      check($sformatf("b2b_valid_%0d", i), {31'b0, vld[0]}, 32'h1);
      check($sformatf("b2b_do_%0d", i), dout[0], 32'(i + 1));
    end
    oe[0] = 1'b0;
    step();
    check("b2b_valid_end", {31'b0, vld[0]}, 32'h0);

    // RD_LAT=3 with a write attempted while busy
    wr(1, 14'h0009, 4'b0000, 32'h0BADF00D);
    a[1] = 14'h0009; oe[1] = 1'b1; web[1] = 4'hF;
    expq[1].push_back(mdl[key(1, 14'h0009)]);
    step();
    oe[1] = 1'b0;
    check("lat3_c1_ready", {31'b0, rdy[1]}, 32'h0);
    check("lat3_c1_valid", {31'b0, vld[1]}, 32'h0);
    web[1] = 4'b0000; di[1] = 32'hFFFFFFFF;
    step();
    web[1] = 4'hF;
    check("lat3_c2_ready", {31'b0, rdy[1]}, 32'h0);
    check("lat3_c2_valid", {31'b0, vld[1]}, 32'h0);
    step();
    check("lat3_c3_ready", {31'b0, rdy[1]}, 32'h1);
    check("lat3_c3_valid", {31'b0, vld[1]}, 32'h1);
    check("lat3_c3_do", dout[1], 32'h0BADF00D);
    step();
    check("lat3_valid_drop", {31'b0, vld[1]}, 32'h0);
    rd(1, 14'h0009, 3);
    check("lat3_busy_write_ignored", dout[1], 32'h0BADF00D);

    // RD_LAT=4 with reset one cycle after acceptance
    wr(2, 14'h0003, 4'b0000, 32'h12345678);
    a[2] = 14'h0003; oe[2] = 1'b1; web[2] = 4'hF;
    expq[2].push_back(mdl[key(2, 14'h0003)]);
    step();
    oe[2] = 1'b0;
    check("lat4_busy_ready", {31'b0, rdy[2]}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq[2].delete();
    check("midrst_ready", {31'b0, rdy[2]}, 32'h1);
    check("midrst_valid", {31'b0, vld[2]}, 32'h0);
    check("midrst_do", dout[2], 32'h0);
    repeat (6) step();
    rd(2, 14'h0003, 4);
    check("lat4_after_rst_do", dout[2], 32'h12345678);
    repeat (2) step();

    for (int k = 0; k < 3; k++)
      check($sformatf("scoreboard_empty_u%0d", k), 32'(expq[k].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
